// File: rtl/manchester_pkg.sv
// Shared types for the Manchester frame decoder: FSM states, interval classes,
// bit-phase tracking and a counter sizing helper.
package manchester_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        RECEIVE = 2'd1,
        DONE    = 2'd2
    } frame_state_e;

    typedef enum logic [1:0] {
        SHORT = 2'd0,
        LONG  = 2'd1,
        BAD   = 2'd2
    } interval_e;

    typedef enum logic [1:0] {
        UNKNOWN  = 2'd0,
        BOUNDARY = 2'd1,
        MID      = 2'd2
    } phase_e;

    // Bits needed to hold values 0..max_count inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/manchester_bit_recovery.sv
// Line synchroniser, edge interval measurement and half-bit phase tracking;
// emits one strobe per decoded Manchester bit.
module manchester_bit_recovery
    import manchester_pkg::*;
#(
    parameter int unsigned HALF_BIT_CYCLES = 8,
    parameter int unsigned TOLERANCE       = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic digital_in,
    output logic bit_strobe,
    output logic bit_data,
    output logic sym_error,
    output logic timeout
);

    localparam int unsigned SAT_COUNT = 2 * HALF_BIT_CYCLES + TOLERANCE + 1;
    localparam int unsigned CW        = cnt_width(SAT_COUNT);

    localparam logic [CW-1:0] SHORT_MIN = CW'(HALF_BIT_CYCLES - TOLERANCE);
    localparam logic [CW-1:0] SHORT_MAX = CW'(HALF_BIT_CYCLES + TOLERANCE);
    localparam logic [CW-1:0] LONG_MIN  = CW'(2 * HALF_BIT_CYCLES - TOLERANCE);
    localparam logic [CW-1:0] LONG_MAX  = CW'(2 * HALF_BIT_CYCLES + TOLERANCE);
    localparam logic [CW-1:0] SAT_C     = CW'(SAT_COUNT);

    logic          sync1;
    logic          sync2;
    logic          sync3;
    logic          edge_c;
    logic [CW-1:0] count;
    phase_e        phase;
    interval_e     interval_c;

    assign edge_c = sync2 ^ sync3;

    // Classify the clocks elapsed since the previous edge.
    always_comb begin
        interval_c = BAD;
        if (count >= SHORT_MIN && count <= SHORT_MAX) begin
            interval_c = SHORT;
        end else if (count >= LONG_MIN && count <= LONG_MAX) begin
            interval_c = LONG;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            count      <= '0;
            phase      <= UNKNOWN;
            bit_strobe <= 1'b0;
            bit_data   <= 1'b0;
            sym_error  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            sync1      <= digital_in;
            sync2      <= sync1;
            sync3      <= sync2;
            bit_strobe <= 1'b0;
            sym_error  <= 1'b0;
            timeout    <= 1'b0;
            if (edge_c) begin
                count <= CW'(1);
                case (interval_c)
                    LONG: begin
                        // A full-bit gap can only end on a mid-bit transition.
                        phase      <= MID;
                        bit_strobe <= 1'b1;
                        bit_data   <= sync2;
                    end
                    SHORT: begin
                        case (phase)
                            BOUNDARY: begin
                                phase      <= MID;
                                bit_strobe <= 1'b1;
                                bit_data   <= sync2;
                            end
                            MID:     phase <= BOUNDARY;
                            default: phase <= UNKNOWN;
                        endcase
                    end
                    default: begin
                        phase     <= UNKNOWN;
                        sym_error <= 1'b1;
                    end
                endcase
            end else if (count != SAT_C) begin
                count <= count + CW'(1);
                if (count == SAT_C - CW'(1)) begin
                    timeout <= 1'b1;
                    phase   <= UNKNOWN;
                end
            end
        end
    end

endmodule

// File: rtl/manchester_frame_decoder.sv
// Preamble hunt, fixed-length frame capture into a byte buffer and a registered
// addressed read port on top of the Manchester bit recovery front end.
module manchester_frame_decoder
    import manchester_pkg::*;
#(
    parameter int unsigned              HALF_BIT_CYCLES = 8,
    parameter int unsigned              TOLERANCE       = 2,
    parameter int unsigned              PREAMBLE_LEN    = 8,
    parameter logic [PREAMBLE_LEN-1:0]  PREAMBLE        = 8'hD5,
    parameter int unsigned              FRAME_BYTES     = 16,
    localparam int unsigned             ADDR_W          = $clog2(FRAME_BYTES)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              digital_in,
    input  logic [ADDR_W-1:0] address,
    output logic [7:0]        parallel_out,
    output logic              valid,
    output logic              transmission_begin,
    output logic              frame_done,
    output logic              error,
    output logic              bit_strobe,
    output logic              bit_data
);

    localparam int unsigned FW         = cnt_width(PREAMBLE_LEN);
    localparam bit          FULL_RANGE = (FRAME_BYTES == (1 << ADDR_W));

    frame_state_e            state;
    logic [PREAMBLE_LEN-1:0] pre_sr;
    logic [PREAMBLE_LEN-1:0] pre_next_c;
    logic [FW-1:0]           pre_fill;
    logic                    match_c;
    logic [6:0]              byte_sr;
    logic [2:0]              bit_idx;
    logic [ADDR_W-1:0]       byte_idx;
    logic [7:0]              buffer [FRAME_BYTES];
    logic                    rx_sym_error;
    logic                    rx_timeout;
    logic                    addr_ok_c;

    manchester_bit_recovery #(
        .HALF_BIT_CYCLES (HALF_BIT_CYCLES),
        .TOLERANCE       (TOLERANCE)
    ) u_bit_recovery (
        .clock      (clock),
        .reset_n    (reset_n),
        .digital_in (digital_in),
        .bit_strobe (bit_strobe),
        .bit_data   (bit_data),
        .sym_error  (rx_sym_error),
        .timeout    (rx_timeout)
    );

    // Match only once a full preamble's worth of bits has been shifted in.
    assign pre_next_c = {pre_sr[PREAMBLE_LEN-2:0], bit_data};
    assign match_c    = (pre_fill == FW'(PREAMBLE_LEN - 1)) && (pre_next_c == PREAMBLE);

    generate
        if (FULL_RANGE) begin : g_full
            assign addr_ok_c = 1'b1;
        end else begin : g_partial
            assign addr_ok_c = (32'(address) < FRAME_BYTES);
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= HUNT;
            pre_sr             <= '0;
            pre_fill           <= '0;
            byte_sr            <= '0;
            bit_idx            <= '0;
            byte_idx           <= '0;
            valid              <= 1'b0;
            error              <= 1'b0;
            transmission_begin <= 1'b0;
            frame_done         <= 1'b0;
            for (int i = 0; i < int'(FRAME_BYTES); i++) begin
                buffer[i] <= '0;
            end
        end else begin
            transmission_begin <= 1'b0;
            frame_done         <= 1'b0;
            case (state)
                HUNT, DONE: begin
                    // DONE keeps hunting; the held frame stays valid until the next match.
                    if (bit_strobe) begin
                        if (match_c) begin
                            transmission_begin <= 1'b1;
                            error              <= 1'b0;
                            valid              <= 1'b0;
                            bit_idx            <= '0;
                            byte_idx           <= '0;
                            pre_sr             <= '0;
                            pre_fill           <= '0;
                            state              <= RECEIVE;
                        end else begin
                            pre_sr <= pre_next_c;
                            if (pre_fill != FW'(PREAMBLE_LEN - 1)) begin
                                pre_fill <= pre_fill + FW'(1);
                            end
                        end
                    end
                end
                RECEIVE: begin
                    if (rx_sym_error || rx_timeout) begin
                        error <= 1'b1;
                        state <= HUNT;
                    end else if (bit_strobe) begin
                        byte_sr <= {byte_sr[5:0], bit_data};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            buffer[byte_idx] <= {byte_sr, bit_data};
                            if (byte_idx == ADDR_W'(FRAME_BYTES - 1)) begin
                                frame_done <= 1'b1;
                                valid      <= 1'b1;
                                state      <= DONE;
                            end else begin
                                byte_idx <= byte_idx + ADDR_W'(1);
                            end
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

    // Reads return zero unless a complete frame is held.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            parallel_out <= '0;
        end else if (valid && addr_ok_c) begin
            parallel_out <= buffer[address];
        end else begin
            parallel_out <= '0;
        end
    end

endmodule
